shift_deserializer: RTL

- Receiving end of the shifter's serial carry path: collects one bit per accepted strobe, as produced on the shifter's C output during repeated single-position shifts, and reassembles a WIDTH-bit word.
- Supports LSB-first streams (produced by right shifts, LR=1) and MSB-first streams (produced by left shifts, LR=0).
- Presents each completed word on a valid/ready output handshake to the CPU datapath or register file.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/shift_deserializer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: deserializer state encoding, default word width and
// serial bit-order constants matching the shifter's LR encoding.
package cpu_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic ORDER_MSB_FIRST = 1'b0;
    localparam logic ORDER_LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

endpackage

// File: rtl/shift_deserializer.sv
// Reassembles WIDTH-bit words from the shifter's serial carry stream and
// presents each finished word on a valid/ready output.
module shift_deserializer
    import cpu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             lr,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             overrun
);

    // Handshake: a word transfers on any rising edge where data_valid and
    // data_ready are both high; data_out is stable while data_valid is high.

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               order_q, order_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;
    logic               data_valid_q, data_valid_d;

    logic [WIDTH-1:0]   shifted;
    logic               accept_start;

    always_comb begin
        if (order_q == ORDER_LSB_FIRST) begin
            shifted = {bit_in, sreg_q[WIDTH-1:1]};
        end else begin
            shifted = {sreg_q[WIDTH-2:0], bit_in};
        end
    end

    // A start in HOLD only counts when the held word is consumed that cycle.
    assign accept_start = start && ((state_q != HOLD) || data_ready);

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        order_d    = order_q;
        overrun_d  = overrun_q;

        if (accept_start) begin
            state_d   = COLLECT;
            count_d   = '0;
            sreg_d    = '0;
            order_d   = lr;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                COLLECT: begin
                    if (bit_valid) begin
                        sreg_d = shifted;
                        if (count_q == CNT_W'(WIDTH - 1)) begin
                            data_out_d = shifted;
                            count_d    = '0;
                            state_d    = HOLD;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (data_ready) begin
                        state_d = IDLE;
                    end else if (bit_valid) begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d       = (state_d == COLLECT);
        data_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            order_q      <= ORDER_MSB_FIRST;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            order_q      <= order_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule
